// File: rtl/or1k_rf_banked_pkg.sv
// rtl/or1k_rf_banked_pkg.sv - shared types and address helpers for the banked register file
package or1k_rf_banked_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam logic [6:0] SPR_GPR_GROUP = 7'h2;

    function automatic int calc_ctx_width(input int contexts);
        return (contexts > 1) ? $clog2(contexts) : 1;
    endfunction

    // Flat RAM index is {context, architectural register}.
    function automatic int calc_rf_addr_width(input int aw, input int contexts);
        return aw + calc_ctx_width(contexts);
    endfunction

endpackage

// File: rtl/or1k_rf_read_port.sv
// rtl/or1k_rf_read_port.sv - one operand port: latched address/context, hold register, forwarding mux
module or1k_rf_read_port #(
    parameter int W       = 32,
    parameter int AW      = 5,
    parameter int CW      = 1,
    parameter int S       = 2,
    parameter int R0_ZERO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [CW-1:0] ctx,
    input  logic [AW-1:0] rd_adr,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_adr,
    input  logic [W-1:0]  wb_dat,
    input  logic [S-1:0]  byp_wb,
    input  logic [S*AW-1:0] byp_adr,
    input  logic [S*W-1:0]  byp_dat,
    input  logic [W-1:0]  ram_dat,
    output logic [W-1:0]  rd_dat
);

    logic [AW-1:0] adr_q;
    logic [CW-1:0] ctx_q;
    logic [W-1:0]  hold_q;
    logic          hold_hit_q;

    // The RAM has no write-through, so a writeback landing on the latched operand is kept here.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q      <= '0;
            ctx_q      <= '0;
            hold_q     <= '0;
            hold_hit_q <= 1'b0;
        end else if (rd_en) begin
            adr_q      <= rd_adr;
            ctx_q      <= ctx;
            hold_q     <= wb_dat;
            hold_hit_q <= wb_we && (wb_adr == rd_adr);
        end else if (wb_we && wb_adr == adr_q && ctx == ctx_q) begin
            hold_q     <= wb_dat;
            hold_hit_q <= 1'b1;
        end
    end

    always_comb begin
        rd_dat = hold_hit_q ? hold_q : ram_dat;
        // Walk oldest to youngest so the lowest matching stage is applied last.
        for (int s = S - 1; s >= 0; s--) begin
            if (byp_wb[s] && byp_adr[s*AW +: AW] == adr_q && ctx == ctx_q)
                rd_dat = byp_dat[s*W +: W];
        end
        if (R0_ZERO != 0 && adr_q == '0)
            rd_dat = '0;
    end

endmodule

// File: rtl/or1k_simple_dpram_sclk.sv
// rtl/or1k_simple_dpram_sclk.sv - single-clock simple dual-port RAM with registered read
module or1k_simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int ENABLE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= din;
        if (re) begin
            if (ENABLE_BYPASS != 0 && we && waddr == raddr)
                dout <= din;
            else
                dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/or1k_rf_banked.sv
// rtl/or1k_rf_banked.sv - multi-port, multi-context register file with clear sequencer and SPR window
module or1k_rf_banked
    import or1k_rf_banked_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_READ_PORTS       = 2,
    parameter int NUM_BYPASS_STAGES    = 2,
    parameter int NUM_CONTEXTS         = 1,
    parameter int OPTION_R0_ZERO       = 0,
    localparam int W  = OPTION_OPERAND_WIDTH,
    localparam int AW = OPTION_RF_ADDR_WIDTH,
    localparam int P  = NUM_READ_PORTS,
    localparam int S  = NUM_BYPASS_STAGES,
    localparam int CW = calc_ctx_width(NUM_CONTEXTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] ctx_i,
    input  logic          rd_en_i,
    input  logic [P*AW-1:0] rd_adr_i,
    output logic [P*W-1:0]  rd_dat_o,
    input  logic [S-1:0]    byp_wb_i,
    input  logic [S*AW-1:0] byp_adr_i,
    input  logic [S*W-1:0]  byp_dat_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [W-1:0]  wb_dat_i,
    input  logic          spr_stb_i,
    input  logic          spr_we_i,
    input  logic [15:0]   spr_addr_i,
    input  logic [W-1:0]  spr_dat_i,
    output logic          spr_ack_o,
    output logic [W-1:0]  spr_dat_o,
    output logic          init_busy_o
);

    localparam int RW = calc_rf_addr_width(AW, NUM_CONTEXTS);
    localparam logic [RW-1:0] LAST_ENTRY = RW'(NUM_CONTEXTS * (2 ** AW) - 1);

    rf_state_e     state_q, state_d;
    logic [RW-1:0] clr_cnt_q, clr_cnt_d;
    logic          run, wb_en, spr_gpr, spr_wr_req, spr_rd_req, spr_wr_ack, spr_rd_ack;
    logic          rd_pend_q, rd_en;
    logic          ram_we;
    logic [RW-1:0] ram_waddr;
    logic [W-1:0]  ram_wdat;
    logic          unused_spr_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ENTRY) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    assign run         = (state_q == ST_RUN);
    assign init_busy_o = !run;
    assign rd_en       = run && rd_en_i;
    assign wb_en       = run && wb_we_i;
    assign spr_gpr     = run && spr_stb_i && (spr_addr_i[15:9] == SPR_GPR_GROUP);
    assign spr_wr_req  = spr_gpr && spr_we_i;
    assign spr_rd_req  = spr_gpr && !spr_we_i;
    assign spr_wr_ack  = spr_wr_req && !wb_en;
    assign spr_rd_ack  = spr_rd_req && rd_pend_q;
    assign spr_ack_o   = spr_wr_ack || spr_rd_ack;
    assign unused_spr_bits = ^spr_addr_i[8:0];

    // Shared write port: clear sequencer, then writeback, then a waiting SPR write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt_q;
        ram_wdat  = '0;
        if (!run) begin
            ram_we = 1'b1;
        end else if (wb_en) begin
            ram_waddr = {ctx_i, wb_adr_i};
            ram_wdat  = wb_dat_i;
            ram_we    = !(OPTION_R0_ZERO != 0 && wb_adr_i == '0);
        end else if (spr_wr_req) begin
            ram_waddr = spr_addr_i[RW-1:0];
            ram_wdat  = spr_dat_i;
            ram_we    = !(OPTION_R0_ZERO != 0 && spr_addr_i[AW-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_pend_q <= 1'b0;
        else if (spr_rd_ack || !spr_rd_req)
            rd_pend_q <= 1'b0;
        else
            rd_pend_q <= 1'b1;
    end

    or1k_simple_dpram_sclk #(.ADDR_WIDTH(RW), .DATA_WIDTH(W), .ENABLE_BYPASS(0)) u_spr_ram (
        .clk   (clk),
        .raddr (spr_addr_i[RW-1:0]),
        .re    (1'b1),
        .waddr (ram_waddr),
        .we    (ram_we),
        .din   (ram_wdat),
        .dout  (spr_dat_o)
    );

    generate
        for (genvar p = 0; p < P; p++) begin : g_port
            logic [W-1:0] ram_dat;
            logic [W-1:0] port_dat;

            or1k_simple_dpram_sclk #(.ADDR_WIDTH(RW), .DATA_WIDTH(W), .ENABLE_BYPASS(0)) u_ram (
                .clk   (clk),
                .raddr ({ctx_i, rd_adr_i[p*AW +: AW]}),
                .re    (rd_en),
                .waddr (ram_waddr),
                .we    (ram_we),
                .din   (ram_wdat),
                .dout  (ram_dat)
            );

            or1k_rf_read_port #(.W(W), .AW(AW), .CW(CW), .S(S), .R0_ZERO(OPTION_R0_ZERO)) u_port (
                .clk     (clk),
                .rst     (rst),
                .rd_en   (rd_en),
                .ctx     (ctx_i),
                .rd_adr  (rd_adr_i[p*AW +: AW]),
                .wb_we   (wb_en),
                .wb_adr  (wb_adr_i),
                .wb_dat  (wb_dat_i),
                .byp_wb  (byp_wb_i),
                .byp_adr (byp_adr_i),
                .byp_dat (byp_dat_i),
                .ram_dat (ram_dat),
                .rd_dat  (port_dat)
            );

            assign rd_dat_o[p*W +: W] = run ? port_dat : '0;
        end
    endgenerate

endmodule

// File: tb/tb_or1k_rf_banked.sv
// tb/tb_or1k_rf_banked.sv - directed self-checking bench for or1k_rf_banked
module tb_or1k_rf_banked;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int P  = 2;
    localparam int S  = 2;
    localparam int C  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:0]      ctx;
    logic            rd_en;
    logic [P*AW-1:0] rd_adr;
    logic [P*W-1:0]  rd_dat;
    logic [S-1:0]    byp_wb;
    logic [S*AW-1:0] byp_adr;
    logic [S*W-1:0]  byp_dat;
    logic            wb_we;
    logic [AW-1:0]   wb_adr;
    logic [W-1:0]    wb_dat;
    logic            spr_stb, spr_we;
    logic [15:0]     spr_addr;
    logic [W-1:0]    spr_wdat, spr_rdat;
    logic            spr_ack, init_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    or1k_rf_banked #(
        .OPTION_OPERAND_WIDTH (W),
        .OPTION_RF_ADDR_WIDTH (AW),
        .NUM_READ_PORTS       (P),
        .NUM_BYPASS_STAGES    (S),
        .NUM_CONTEXTS         (C),
        .OPTION_R0_ZERO       (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctx_i       (ctx),
        .rd_en_i     (rd_en),
        .rd_adr_i    (rd_adr),
        .rd_dat_o    (rd_dat),
        .byp_wb_i    (byp_wb),
        .byp_adr_i   (byp_adr),
        .byp_dat_i   (byp_dat),
        .wb_we_i     (wb_we),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_dat),
        .spr_stb_i   (spr_stb),
        .spr_we_i    (spr_we),
        .spr_addr_i  (spr_addr),
        .spr_dat_i   (spr_wdat),
        .spr_ack_o   (spr_ack),
        .spr_dat_o   (spr_rdat),
        .init_busy_o (init_busy)
    );

    task automatic idle();
        ctx = 1'b0; rd_en = 1'b0; rd_adr = '0;
        byp_wb = '0; byp_adr = '0; byp_dat = '0;
        wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
        spr_stb = 1'b0; spr_we = 1'b0; spr_addr = '0; spr_wdat = '0;
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic c);
        ctx = c; rd_adr = {a1, a0}; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic spr_read(input logic [15:0] addr, output logic [W-1:0] data, output int lat);
        spr_stb = 1'b1; spr_we = 1'b0; spr_addr = addr;
        lat = 0; data = '0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            if (spr_ack) begin lat = i; data = spr_rdat; end
        end
        spr_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (init_busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc, lat;
        logic [W-1:0] d;
        rst = 1'b1; idle();
        repeat (2) @(negedge clk);
        n_checks++; if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
        n_checks++; if (spr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", spr_ack); end
        n_checks++; if (rd_dat !== '0) begin n_fail++; $display("FAIL reset_rd_dat: got %h expected 0", rd_dat); end
        rst = 1'b0;
        wait_clear(cyc);
        n_checks++; if (cyc != 64) begin n_fail++; $display("FAIL clear_len: got %0d expected 64", cyc); end
        for (int a = 0; a < 64; a++) begin
            spr_read(16'h0400 + 16'(a), d, lat);
            n_checks++;
            if (lat != 1 || d !== 32'h0) begin
                n_fail++; $display("FAIL clear_spr_%0h: got %h lat %0d expected 0 lat 1", 16'h0400 + a, d, lat);
            end
        end
    endtask

    task automatic test_hazard();
        ctx = 1'b0; wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'hDEADBEEF;
        read2(5'd3, 5'd4, 1'b0);
        wb_we = 1'b0;
        n_checks++; if (rd_dat[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hazard_same_cycle: got %h expected deadbeef", rd_dat[31:0]); end
        n_checks++; if (rd_dat[63:32] !== 32'h0) begin n_fail++; $display("FAIL hazard_port1: got %h expected 0", rd_dat[63:32]); end
        wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'h1;
        @(negedge clk);
        wb_we = 1'b0;
        n_checks++; if (rd_dat[31:0] !== 32'h1) begin n_fail++; $display("FAIL hazard_hold: got %h expected 1", rd_dat[31:0]); end
        read2(5'd3, 5'd0, 1'b0);
        n_checks++; if (rd_dat !== {32'h0, 32'h1}) begin n_fail++; $display("FAIL hazard_ram: got %h expected 0000000000000001", rd_dat); end
    endtask

    task automatic test_forward();
        read2(5'd5, 5'd5, 1'b0);
        byp_wb = 2'b11; byp_adr = {5'd5, 5'd5}; byp_dat = {32'h5555, 32'hAAAA};
        #1;
        n_checks++; if (rd_dat !== {32'hAAAA, 32'hAAAA}) begin n_fail++; $display("FAIL fwd_stage0: got %h expected aaaa on both", rd_dat); end
        byp_wb = 2'b10;
        #1;
        n_checks++; if (rd_dat[31:0] !== 32'h5555) begin n_fail++; $display("FAIL fwd_stage1: got %h expected 5555", rd_dat[31:0]); end
        ctx = 1'b1; byp_wb = 2'b11;
        #1;
        n_checks++; if (rd_dat[31:0] !== 32'h0) begin n_fail++; $display("FAIL fwd_ctx_mismatch: got %h expected 0", rd_dat[31:0]); end
        ctx = 1'b0; byp_wb = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_context();
        int lat;
        logic [W-1:0] d;
        ctx = 1'b1; wb_we = 1'b1; wb_adr = 5'd7; wb_dat = 32'h77;
        @(negedge clk);
        wb_we = 1'b0;
        read2(5'd7, 5'd0, 1'b0);
        n_checks++; if (rd_dat[31:0] !== 32'h0) begin n_fail++; $display("FAIL ctx0_r7: got %h expected 0", rd_dat[31:0]); end
        read2(5'd7, 5'd0, 1'b1);
        n_checks++; if (rd_dat[31:0] !== 32'h77) begin n_fail++; $display("FAIL ctx1_r7: got %h expected 77", rd_dat[31:0]); end
        ctx = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_dat[31:0] !== 32'h77) begin n_fail++; $display("FAIL ctx_switch_latched: got %h expected 77", rd_dat[31:0]); end
        spr_read(16'h0427, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h77) begin n_fail++; $display("FAIL spr_read_427: got %h lat %0d expected 77 lat 1", d, lat); end
        spr_read(16'h0407, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL spr_read_407: got %h lat %0d expected 0 lat 1", d, lat); end
    endtask

    task automatic test_spr_contention();
        ctx = 1'b0; wb_we = 1'b1; wb_adr = 5'd1; wb_dat = 32'h11;
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h040A; spr_wdat = 32'h12;
        #1;
        n_checks++; if (spr_ack !== 1'b0) begin n_fail++; $display("FAIL spr_wr_blocked: got %b expected 0", spr_ack); end
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        n_checks++; if (spr_ack !== 1'b1) begin n_fail++; $display("FAIL spr_wr_ack: got %b expected 1", spr_ack); end
        @(negedge clk);
        spr_stb = 1'b0; spr_we = 1'b0;
        read2(5'd10, 5'd1, 1'b0);
        n_checks++; if (rd_dat !== {32'h11, 32'h12}) begin n_fail++; $display("FAIL spr_wr_data: got %h expected 0000001100000012", rd_dat); end
    endtask

    task automatic test_back_to_back();
        ctx = 1'b0; rd_adr = {5'd0, 5'd3}; rd_en = 1'b1;
        @(negedge clk);
        n_checks++; if (rd_dat[31:0] !== 32'h1) begin n_fail++; $display("FAIL b2b_first: got %h expected 1", rd_dat[31:0]); end
        rd_adr = {5'd0, 5'd10}; wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'hBAD;
        @(negedge clk);
        rd_en = 1'b0; wb_we = 1'b0;
        n_checks++; if (rd_dat[31:0] !== 32'h12) begin n_fail++; $display("FAIL b2b_new_addr_wins: got %h expected 12", rd_dat[31:0]); end
        read2(5'd3, 5'd0, 1'b0);
        n_checks++; if (rd_dat[31:0] !== 32'hBAD) begin n_fail++; $display("FAIL b2b_wb_landed: got %h expected bad", rd_dat[31:0]); end
    endtask

    task automatic test_r0();
        int lat;
        logic [W-1:0] d;
        ctx = 1'b0; wb_we = 1'b1; wb_adr = 5'd0; wb_dat = 32'hFF;
        read2(5'd0, 5'd3, 1'b0);
        wb_we = 1'b0;
        n_checks++; if (rd_dat !== {32'hBAD, 32'h0}) begin n_fail++; $display("FAIL r0_hazard: got %h expected 00000bad00000000", rd_dat); end
        read2(5'd0, 5'd0, 1'b0);
        n_checks++; if (rd_dat !== '0) begin n_fail++; $display("FAIL r0_read: got %h expected 0", rd_dat); end
        spr_read(16'h0400, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL r0_spr: got %h lat %0d expected 0 lat 1", d, lat); end
    endtask

    task automatic test_ignored_spr();
        int lat;
        logic seen;
        logic [W-1:0] d;
        seen = 1'b0;
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h0804; spr_wdat = 32'hFFFF;
        #1 seen = spr_ack;
        repeat (2) begin
            @(negedge clk);
            seen = seen | spr_ack;
        end
        spr_we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | spr_ack;
        end
        spr_stb = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL spr_other_group_ack: got %b expected 0", seen); end
        @(negedge clk);
        spr_read(16'h0404, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL spr_other_group_write: got %h lat %0d expected 0 lat 1", d, lat); end
    endtask

    task automatic test_mid_clear_reset();
        int cyc, lat;
        logic [W-1:0] d;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rd_en = 1'b1; rd_adr = {5'd3, 5'd10};
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h040A; spr_wdat = 32'h99;
        #1;
        n_checks++; if (init_busy !== 1'b1) begin n_fail++; $display("FAIL midclear_busy: got %b expected 1", init_busy); end
        n_checks++; if (spr_ack !== 1'b0) begin n_fail++; $display("FAIL midclear_ack: got %b expected 0", spr_ack); end
        @(negedge clk);
        n_checks++; if (rd_dat !== '0) begin n_fail++; $display("FAIL midclear_rd_dat: got %h expected 0", rd_dat); end
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear(cyc);
        n_checks++; if (cyc != 64) begin n_fail++; $display("FAIL midclear_len: got %0d expected 64", cyc); end
        spr_read(16'h0427, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL midclear_427: got %h lat %0d expected 0 lat 1", d, lat); end
        spr_read(16'h040A, d, lat);
        n_checks++; if (lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL midclear_40a: got %h lat %0d expected 0 lat 1", d, lat); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hazard();
        test_forward();
        test_context();
        test_spr_contention();
        test_back_to_back();
        test_r0();
        test_ignored_spr();
        test_mid_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
